// File: rtl/imem_dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the instruction/data memory
//            arbiter: FSM state encoding, transaction owner encoding, the
//            doubleword alignment width and an address-alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_ALIGN_BITS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Clears the byte-offset bits so the memory always sees a doubleword address.
    function automatic logic [63:0] align_dw(input logic [63:0] addr);
        return addr & ~((64'd1 << ADDR_ALIGN_BITS) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_dmem_arbiter_if
// Purpose  : Bundles the core-facing fetch/data ports and the unified
//            memory port of the arbiter.
// Modports : slave  - the arbiter (consumes core requests and memory
//                     responses, produces core responses and memory requests)
//            master - the surrounding core + memory environment
// Revision : 1.0 - initial release
// ============================================================================
interface imem_dmem_arbiter_if;

    // Instruction fetch port
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_inst;
    logic        i_err;

    // Data port
    logic        d_valid;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ready;
    logic [63:0] d_rdata;
    logic        d_err;

    // Unified memory port
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport slave (
        input  i_valid, i_addr, d_valid, d_we, d_addr, d_wdata,
        input  mem_gnt, mem_ack, mem_rdata,
        output i_ready, i_inst, i_err, d_ready, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_valid, i_addr, d_valid, d_we, d_addr, d_wdata,
        output mem_gnt, mem_ack, mem_rdata,
        input  i_ready, i_inst, i_err, d_ready, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/imem_dmem_arbiter_arb_prio_starve.sv
`default_nettype none
// ============================================================================
// Module   : arb_prio_starve
// Purpose  : Data-first grant selection with an instruction anti-starvation
//            guard. Grants are combinational and only valid while arb_en_i
//            is high (arbiter idle). Owns the saturating starve counter.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            arb_en_i      - arbiter is in its decision cycle
//            i_valid_i     - fetch request pending
//            d_valid_i     - data request pending
//            grant_i_o     - fetch wins this decision
//            grant_d_o     - data wins this decision
// Revision : 1.0 - initial release
// ============================================================================
module arb_prio_starve #(
    parameter int STARVE_MAX = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic arb_en_i,
    input  wire logic i_valid_i,
    input  wire logic d_valid_i,
    output logic      grant_i_o,
    output logic      grant_d_o
);

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0] starve_q;

    always_comb begin
        grant_d_o = arb_en_i && d_valid_i && (!i_valid_i || (starve_q < STARVE_LIMIT));
        grant_i_o = arb_en_i && i_valid_i && !grant_d_o;
    end

    // Counts D grants that bypassed a waiting fetch; any decision cycle with
    // no fetch pending, or a fetch grant, restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else if (arb_en_i) begin
            if (grant_i_o || !i_valid_i) begin
                starve_q <= 4'd0;
            end else if (grant_d_o && (starve_q != 4'hF)) begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_dmem_arbiter
// Purpose  : Shares one 64-bit memory port between the instruction-fetch and
//            data ports of a core. One transaction in flight; IDLE picks an
//            owner, REQ holds mem_req until mem_gnt, WAIT waits for mem_ack
//            (or aborts after TIMEOUT cycles), RESP pulses the owner's ready.
// Ports    : clk  - clock
//            rst  - asynchronous active-high reset
//            bus  - imem_dmem_arbiter_if.slave (core + memory signals)
// Revision : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input wire logic            clk,
    input wire logic            rst,
    imem_dmem_arbiter_if.slave  bus
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    owner_t      owner_q;
    logic        sel_hi_q;
    logic [7:0]  tmo_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_wdata_q;
    logic        i_ready_q;
    logic [31:0] i_inst_q;
    logic        i_err_q;
    logic        d_ready_q;
    logic [63:0] d_rdata_q;
    logic        d_err_q;

    logic        grant_i;
    logic        grant_d;

    arb_prio_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .arb_en_i  (state_q == IDLE),
        .i_valid_i (bus.i_valid),
        .d_valid_i (bus.d_valid),
        .grant_i_o (grant_i),
        .grant_d_o (grant_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            sel_hi_q    <= 1'b0;
            tmo_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
            i_ready_q   <= 1'b0;
            i_inst_q    <= 32'd0;
            i_err_q     <= 1'b0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= 64'd0;
            d_err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        owner_q     <= OWN_D;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= align_dw(bus.d_addr);
                        mem_wdata_q <= bus.d_wdata;
                        sel_hi_q    <= 1'b0;
                        mem_req_q   <= 1'b1;
                        state_q     <= REQ;
                    end else if (grant_i) begin
                        owner_q     <= OWN_I;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= align_dw({32'd0, bus.i_addr});
                        mem_wdata_q <= 64'd0;
                        // Picks which 32-bit half of the doubleword is the instruction.
                        sel_hi_q    <= bus.i_addr[2];
                        mem_req_q   <= 1'b1;
                        state_q     <= REQ;
                    end
                end

                REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        tmo_q     <= 8'd0;
                        state_q   <= WAIT;
                    end
                end

                WAIT: begin
                    // An ack on the final allowed cycle still counts as success.
                    if (bus.mem_ack) begin
                        if (owner_q == OWN_I) begin
                            i_inst_q  <= sel_hi_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                            i_ready_q <= 1'b1;
                        end else begin
                            d_rdata_q <= bus.mem_rdata;
                            d_ready_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else if (tmo_q == TMO_LAST) begin
                        if (owner_q == OWN_I) begin
                            i_ready_q <= 1'b1;
                            i_err_q   <= 1'b1;
                        end else begin
                            d_ready_q <= 1'b1;
                            d_err_q   <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end

                RESP: begin
                    i_ready_q <= 1'b0;
                    i_err_q   <= 1'b0;
                    d_ready_q <= 1'b0;
                    d_err_q   <= 1'b0;
                    state_q   <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.i_inst    = i_inst_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_dmem_arbiter
// Purpose  : Self-checking bench for imem_dmem_arbiter: directed vector table
//            for single transactions, plus sequences for contention, a
//            stalled memory, timeout and asynchronous reset mid-transaction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [63:0] exp_addr;
        logic [63:0] exp_data;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mlog_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    // Memory model controls and state
    int          gnt_dly = 0;
    int          ack_dly = 0;
    bit          ack_en  = 1'b1;
    logic [63:0] rdata_val = 64'd0;
    int          ph = 0;
    int          cnt = 0;
    int          req_cycles = 0;
    mlog_t       mlog[$];

    vec_t vecs[6];

    imem_dmem_arbiter_if bus ();

    imem_dmem_arbiter #(
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: grants after gnt_dly idle REQ cycles, acks after ack_dly idle WAIT cycles.
    initial begin
        bus.mem_gnt   = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'd0;
        forever begin
            @(negedge clk);
            bus.mem_gnt = 1'b0;
            bus.mem_ack = 1'b0;
            if (rst) begin
                ph = 0; cnt = 0;
            end else if (bus.i_ready || bus.d_ready) begin
                ph = 0; cnt = 0;
            end else if (ph == 0) begin
                if (bus.mem_req) begin
                    req_cycles++;
                    if (cnt == gnt_dly) begin
                        bus.mem_gnt = 1'b1;
                        mlog.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
                        ph = 1; cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                if (ack_en && cnt == ack_dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata_val;
                    ph = 0; cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issues one request, waits (bounded) for its ready pulse; returns with
    // the pulse visible and both valids dropped.
    task automatic txn(input logic is_d, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input string nm,
                       output int lat);
        int  c0;
        bit  got;
        @(negedge clk);
        if (is_d) begin
            bus.d_valid = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_valid = 1'b1; bus.i_addr = addr[31:0];
        end
        c0  = cyc;
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (is_d ? bus.d_ready : bus.i_ready) begin
                got = 1'b1;
                lat = cyc - c0;
            end
        end
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        chk({nm, "_ready_seen"}, 64'(got), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat;
        int extra;

        vecs[0] = '{1'b0, 1'b0, 64'h1004,      64'h0, 64'hAAAA_BBBB_1111_2222, 64'h1000,      64'hAAAA_BBBB,            1'b1};
        vecs[1] = '{1'b0, 1'b0, 64'h2000,      64'h0, 64'hAAAA_BBBB_1111_2222, 64'h2000,      64'h1111_2222,            1'b1};
        vecs[2] = '{1'b1, 1'b1, 64'h2008,      64'hDEADBEEF_00000001, 64'h0,   64'h2008,      64'h0,                    1'b0};
        vecs[3] = '{1'b1, 1'b0, 64'h2008,      64'h0, 64'hDEADBEEF_00000001,   64'h2008,      64'hDEADBEEF_00000001,    1'b1};
        vecs[4] = '{1'b1, 1'b0, 64'h300F,      64'h0, 64'h0123_4567_89AB_CDEF, 64'h3008,      64'h0123_4567_89AB_CDEF,  1'b1};
        vecs[5] = '{1'b0, 1'b0, 64'hFFFF_FFFC, 64'h0, 64'hCAFE_F00D_1234_5678, 64'hFFFF_FFF8, 64'hCAFE_F00D,            1'b1};

        bus.i_valid = 1'b0; bus.i_addr = 32'd0;
        bus.d_valid = 1'b0; bus.d_we = 1'b0; bus.d_addr = 64'd0; bus.d_wdata = 64'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_mem_req",   64'(bus.mem_req), 64'd0);
        chk("rst_mem_we",    64'(bus.mem_we),  64'd0);
        chk("rst_mem_addr",  bus.mem_addr,     64'd0);
        chk("rst_mem_wdata", bus.mem_wdata,    64'd0);
        chk("rst_readys",    64'({bus.i_ready, bus.d_ready, bus.i_err, bus.d_err}), 64'd0);
        chk("rst_i_inst",    64'(bus.i_inst),  64'd0);
        chk("rst_d_rdata",   bus.d_rdata,      64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- table-driven single transactions ----------------
        for (int v = 0; v < 6; v++) begin
            mlog.delete();
            rdata_val = vecs[v].rdata;
            txn(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, $sformatf("v%0d", v), lat);
            chk($sformatf("v%0d_latency", v), 64'(lat), 64'd3);
            if (vecs[v].is_d) begin
                chk($sformatf("v%0d_d_err", v), 64'(bus.d_err), 64'd0);
                chk($sformatf("v%0d_i_ready_quiet", v), 64'(bus.i_ready), 64'd0);
                if (vecs[v].chk_data) chk($sformatf("v%0d_d_rdata", v), bus.d_rdata, vecs[v].exp_data);
            end else begin
                chk($sformatf("v%0d_i_err", v), 64'(bus.i_err), 64'd0);
                chk($sformatf("v%0d_d_ready_quiet", v), 64'(bus.d_ready), 64'd0);
                if (vecs[v].chk_data) chk($sformatf("v%0d_i_inst", v), 64'(bus.i_inst), vecs[v].exp_data);
            end
            chk($sformatf("v%0d_grants", v), 64'(mlog.size()), 64'd1);
            if (mlog.size() > 0) begin
                chk($sformatf("v%0d_mem_addr", v), mlog[0].addr, vecs[v].exp_addr);
                chk($sformatf("v%0d_mem_we", v), 64'(mlog[0].we), 64'(vecs[v].we));
                if (vecs[v].we) chk($sformatf("v%0d_mem_wdata", v), mlog[0].wdata, vecs[v].wdata);
            end
            @(negedge clk);
            chk($sformatf("v%0d_pulse_width", v), 64'({bus.i_ready, bus.d_ready}), 64'd0);
        end

        // ---------------- contention: D,D,D,D,I repeating ----------------
        mlog.delete();
        rdata_val = 64'h0;
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_addr = 32'h4000;
        bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h8000;
        for (int k = 0; k < 300 && mlog.size() < 10; k++) @(negedge clk);
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        chk("cont_grant_count", 64'(mlog.size() >= 10), 64'd1);
        repeat (12) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k < mlog.size())
                chk($sformatf("cont_order%0d", k), mlog[k].addr, (k % 5 == 4) ? 64'h4000 : 64'h8000);
        end

        // ---------------- stalled memory ----------------
        // gnt withheld for the first 5 REQ cycles and given in the 6th; ack in
        // the 7th WAIT cycle. Latency = 1 (IDLE) + 6 (REQ) + 7 (WAIT) = 14.
        gnt_dly = 5; ack_dly = 6; req_cycles = 0;
        rdata_val = 64'h5555_6666_7777_8888;
        txn(1'b1, 1'b0, 64'h5000, 64'h0, "stall", lat);
        chk("stall_latency",   64'(lat), 64'd14);
        chk("stall_req_cycles", 64'(req_cycles), 64'd6);
        chk("stall_d_err",     64'(bus.d_err), 64'd0);
        chk("stall_d_rdata",   bus.d_rdata, 64'h5555_6666_7777_8888);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.d_ready) extra++;
        end
        chk("stall_single_pulse", 64'(extra), 64'd0);
        gnt_dly = 0; ack_dly = 0;

        // ---------------- timeout (TIMEOUT=8) ----------------
        // Latency = 1 (IDLE) + 1 (REQ) + 8 (WAIT) = 10; read data is unchanged.
        ack_en = 1'b0;
        rdata_val = 64'hFFFF_FFFF_FFFF_FFFF;
        txn(1'b1, 1'b0, 64'h6000, 64'h0, "tmo", lat);
        chk("tmo_latency", 64'(lat), 64'd10);
        chk("tmo_d_err",   64'(bus.d_err), 64'd1);
        chk("tmo_d_rdata_kept", bus.d_rdata, 64'h5555_6666_7777_8888);
        @(negedge clk);
        chk("tmo_err_clears", 64'({bus.d_ready, bus.d_err}), 64'd0);
        ack_en = 1'b1;
        rdata_val = 64'h0BAD_F00D_0000_0042;
        txn(1'b1, 1'b0, 64'h6000, 64'h0, "post_tmo", lat);
        chk("post_tmo_latency", 64'(lat), 64'd3);
        chk("post_tmo_d_err",   64'(bus.d_err), 64'd0);
        chk("post_tmo_d_rdata", bus.d_rdata, 64'h0BAD_F00D_0000_0042);
        @(negedge clk);

        // ---------------- async reset during WAIT ----------------
        ack_en = 1'b0;
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h7008; bus.d_wdata = 64'h1234;
        repeat (3) @(negedge clk);
        chk("pre_rst_mem_addr", bus.mem_addr, 64'h7008);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_addr",  bus.mem_addr,  64'd0);
        chk("arst_mem_wdata", bus.mem_wdata, 64'd0);
        chk("arst_ctrl",      64'({bus.mem_req, bus.mem_we, bus.d_ready, bus.d_err}), 64'd0);
        chk("arst_d_rdata",   bus.d_rdata,   64'd0);
        bus.d_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.d_ready || bus.i_ready || bus.mem_req) extra++;
        end
        chk("arst_no_activity", 64'(extra), 64'd0);
        rdata_val = 64'h9999_0000_8765_4321;
        txn(1'b0, 1'b0, 64'h0000_9000, 64'h0, "post_rst", lat);
        chk("post_rst_latency", 64'(lat), 64'd3);
        chk("post_rst_i_inst",  64'(bus.i_inst), 64'h8765_4321);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
